// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with an input FIFO.
// Frames go out back-to-back while words are queued.
module uart_tx_cfg #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [15:0]      BAUD_LAST = 16'(CYCLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Ready depends only on registered occupancy, so a pop cannot free a slot in the same edge.
  assign tx_data_ready = (level_q != FULL_LVL);
  assign push          = tx_data_valid && tx_data_ready;
  assign head          = mem_q[rd_ptr_q];

  // NOTE: the storage array is not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Serialiser
  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_pin_q, pin_d;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = '0;
    stop_d   = stop_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pin_d    = 1'b1;
    pop      = 1'b0;

    if (state_q != S_IDLE) baud_d = bit_end ? 16'd0 : baud_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        pin_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        pin_d = shift_q[0];
        bit_d = bit_q;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        pin_d = parity_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            stop_d = 1'b0;
            if (level_q != '0) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = head;
      parity_d = (^head) ^ ODD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_pin_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_pin_q <= pin_d;
    end
  end

  assign tx_pin     = tx_pin_q;
  assign tx_busy    = (state_q != S_IDLE) || (level_q != '0);
  assign fifo_level = level_q;

endmodule
